// File: rtl/mdpt_trainer.sv
// mdpt_trainer: serializes LSQ violation and false-dependence reports into
// single-entry MDPT writes. Violations are buffered in a small FIFO and each
// produces a load write followed by a store write with a merged store-set id.
// False dependences decay the load's confidence in a single write.
module mdpt_trainer #(
  parameter int unsigned VIOL_FIFO_DEPTH = 4,
  parameter int unsigned SSID_WIDTH      = 6,
  parameter int unsigned CONF_WIDTH      = 2,
  localparam int unsigned MDPW           = CONF_WIDTH + SSID_WIDTH,
  localparam int unsigned PCW            = 38
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            viol_valid,
  output logic            viol_ready,
  input  logic [PCW-1:0]  viol_load_pc38,
  input  logic [MDPW-1:0] viol_load_mdp,
  input  logic [PCW-1:0]  viol_store_pc38,
  input  logic [MDPW-1:0] viol_store_mdp,
  input  logic            fdep_valid,
  output logic            fdep_ready,
  input  logic [PCW-1:0]  fdep_pc38,
  input  logic [MDPW-1:0] fdep_mdp,
  output logic            update_valid,
  output logic [PCW-1:0]  update_pc38,
  output logic [MDPW-1:0] update_mdp
);

  localparam int unsigned PTRW = (VIOL_FIFO_DEPTH > 1) ? $clog2(VIOL_FIFO_DEPTH) : 1;
  localparam int unsigned CNTW = PTRW + 1;

  typedef struct packed {
    logic [PCW-1:0]  load_pc;
    logic [MDPW-1:0] load_mdp;
    logic [PCW-1:0]  store_pc;
    logic [MDPW-1:0] store_mdp;
  } viol_entry_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_LOAD  = 2'd1,
    WR_STORE = 2'd2,
    WR_FDEP  = 2'd3
  } state_t;

  state_t                state;
  viol_entry_t           mem [VIOL_FIFO_DEPTH];
  logic [PTRW-1:0]       rd_ptr;
  logic [PTRW-1:0]       wr_ptr;
  logic [CNTW-1:0]       count;
  logic [SSID_WIDTH-1:0] alloc_ctr;

  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  push;
  logic                  pop;
  logic                  fdep_fire;
  viol_entry_t           head;

  logic [CONF_WIDTH-1:0] load_conf;
  logic [CONF_WIDTH-1:0] store_conf;
  logic [SSID_WIDTH-1:0] load_ssid;
  logic [SSID_WIDTH-1:0] store_ssid;
  logic                  need_alloc;
  logic [SSID_WIDTH-1:0] merged_ssid;
  logic [MDPW-1:0]       merged_mdp;
  logic [CONF_WIDTH-1:0] fdep_conf;
  logic [MDPW-1:0]       fdep_decayed;

  // Handshakes: no bypass of a same-cycle pop into viol_ready.
  assign fifo_empty = (count == CNTW'(0));
  assign fifo_full  = (count == CNTW'(VIOL_FIFO_DEPTH));
  assign viol_ready = !fifo_full;
  assign fdep_ready = fifo_empty && (state != WR_LOAD);
  assign push       = viol_valid && viol_ready;
  assign pop        = (state == WR_LOAD);
  assign fdep_fire  = fdep_valid && fdep_ready;
  assign head       = mem[rd_ptr];

  // Store-set merge of the head violation: allocate, inherit, or take the smaller id.
  always_comb begin
    load_conf   = head.load_mdp[MDPW-1:SSID_WIDTH];
    store_conf  = head.store_mdp[MDPW-1:SSID_WIDTH];
    load_ssid   = head.load_mdp[SSID_WIDTH-1:0];
    store_ssid  = head.store_mdp[SSID_WIDTH-1:0];
    need_alloc  = 1'b0;
    merged_ssid = alloc_ctr;
    if (load_conf == CONF_WIDTH'(0) && store_conf == CONF_WIDTH'(0)) begin
      need_alloc  = 1'b1;
      merged_ssid = alloc_ctr;
    end else if (store_conf == CONF_WIDTH'(0)) begin
      merged_ssid = load_ssid;
    end else if (load_conf == CONF_WIDTH'(0)) begin
      merged_ssid = store_ssid;
    end else begin
      merged_ssid = (load_ssid < store_ssid) ? load_ssid : store_ssid;
    end
    merged_mdp = {{CONF_WIDTH{1'b1}}, merged_ssid};
  end

  // False-dependence decay: confidence minus one, store-set id kept.
  always_comb begin
    fdep_conf    = fdep_mdp[MDPW-1:SSID_WIDTH];
    fdep_decayed = {CONF_WIDTH'(fdep_conf - CONF_WIDTH'(1)), fdep_mdp[SSID_WIDTH-1:0]};
  end

  // FIFO storage; contents are meaningful only between rd_ptr and wr_ptr.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= '{load_pc:   viol_load_pc38,
                       load_mdp:  viol_load_mdp,
                       store_pc:  viol_store_pc38,
                       store_mdp: viol_store_mdp};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= PTRW'(wr_ptr + PTRW'(1));
      if (pop)  rd_ptr <= PTRW'(rd_ptr + PTRW'(1));
      case ({push, pop})
        2'b10:   count <= CNTW'(count + CNTW'(1));
        2'b01:   count <= CNTW'(count - CNTW'(1));
        default: count <= count;
      endcase
    end
  end

  // Write sequencer: load then store per violation, fdep only when the FIFO is idle.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state        <= IDLE;
      update_valid <= 1'b0;
      update_pc38  <= '0;
      update_mdp   <= '0;
      alloc_ctr    <= '0;
    end else begin
      if (state == WR_LOAD) begin
        state        <= WR_STORE;
        update_valid <= 1'b1;
        update_pc38  <= head.store_pc;
        update_mdp   <= merged_mdp;
        if (need_alloc) alloc_ctr <= SSID_WIDTH'(alloc_ctr + SSID_WIDTH'(1));
      end else if (!fifo_empty) begin
        state        <= WR_LOAD;
        update_valid <= 1'b1;
        update_pc38  <= head.load_pc;
        update_mdp   <= merged_mdp;
      end else if (fdep_fire && fdep_conf != CONF_WIDTH'(0)) begin
        state        <= WR_FDEP;
        update_valid <= 1'b1;
        update_pc38  <= fdep_pc38;
        update_mdp   <= fdep_decayed;
      end else begin
        state        <= IDLE;
        update_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mdpt_trainer.sv
// Directed bench for mdpt_trainer with a write scoreboard.
module tb_mdpt_trainer;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        viol_valid;
  logic        viol_ready;
  logic [37:0] viol_load_pc38;
  logic [7:0]  viol_load_mdp;
  logic [37:0] viol_store_pc38;
  logic [7:0]  viol_store_mdp;
  logic        fdep_valid;
  logic        fdep_ready;
  logic [37:0] fdep_pc38;
  logic [7:0]  fdep_mdp;
  logic        update_valid;
  logic [37:0] update_pc38;
  logic [7:0]  update_mdp;

  mdpt_trainer dut (
    .CLK(CLK), .nRST(nRST),
    .viol_valid(viol_valid), .viol_ready(viol_ready),
    .viol_load_pc38(viol_load_pc38), .viol_load_mdp(viol_load_mdp),
    .viol_store_pc38(viol_store_pc38), .viol_store_mdp(viol_store_mdp),
    .fdep_valid(fdep_valid), .fdep_ready(fdep_ready),
    .fdep_pc38(fdep_pc38), .fdep_mdp(fdep_mdp),
    .update_valid(update_valid), .update_pc38(update_pc38), .update_mdp(update_mdp)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          cyc;
    logic [37:0] pc;
    logic [7:0]  mdp;
  } exp_t;

  exp_t       sb[$];
  int         vectors     = 0;
  int         miscompares = 0;
  int         cyc         = 0;
  int         busy_from   = -1;
  int         busy_until  = -1;
  logic       saw_full    = 1'b0;
  logic [5:0] m_ctr       = 6'd0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [7:0] merge_model(input logic [7:0] lm, input logic [7:0] sm);
    logic [5:0] s;
    if (lm[7:6] == 2'd0 && sm[7:6] == 2'd0) s = m_ctr;
    else if (sm[7:6] == 2'd0)               s = lm[5:0];
    else if (lm[7:6] == 2'd0)               s = sm[5:0];
    else                                    s = (lm[5:0] < sm[5:0]) ? lm[5:0] : sm[5:0];
    return {2'b11, s};
  endfunction

  function automatic logic [7:0] fdep_model(input logic [7:0] m);
    logic [1:0] c;
    c = m[7:6] - 2'd1;
    return {c, m[5:0]};
  endfunction

  // One clock: advance, then score any write seen in the new cycle.
  task automatic tick();
    exp_t e;
    @(posedge CLK);
    #1;
    cyc++;
    if (!viol_ready) saw_full = 1'b1;
    if (cyc > busy_from && cyc <= busy_until) check("fdep_ready_busy", 64'(fdep_ready), 64'd0);
    if (update_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_write", 64'(update_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        check("wr_pc", 64'(update_pc38), 64'(e.pc));
        check("wr_mdp", 64'(update_mdp), 64'(e.mdp));
        if (e.cyc >= 0) check("wr_cycle", 64'(cyc), 64'(e.cyc));
      end
    end else if (sb.size() > 0 && sb[0].cyc >= 0 && sb[0].cyc <= cyc) begin
      check("missing_write", 64'(update_valid), 64'd1);
      void'(sb.pop_front());
    end
  endtask

  // Present a violation and hold it until accepted; viol_valid is left high.
  task automatic send_viol(input logic [37:0] lpc, input logic [7:0] lm,
                           input logic [37:0] spc, input logic [7:0] sm,
                           input int lcyc, input int scyc);
    logic [7:0] m;
    viol_valid      = 1'b1;
    viol_load_pc38  = lpc;
    viol_load_mdp   = lm;
    viol_store_pc38 = spc;
    viol_store_mdp  = sm;
    for (int k = 0; k < 50 && !viol_ready; k++) tick();
    check("viol_ready_wait", 64'(viol_ready), 64'd1);
    m = merge_model(lm, sm);
    sb.push_back('{cyc: lcyc, pc: lpc, mdp: m});
    sb.push_back('{cyc: scyc, pc: spc, mdp: m});
    if (lm[7:6] == 2'd0 && sm[7:6] == 2'd0) m_ctr = m_ctr + 6'd1;
    tick();
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && sb.size() > 0; k++) tick();
    check("drain_empty", 64'(sb.size()), 64'd0);
    tick();
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    nRST = 1'b0;
    viol_valid = 1'b0; viol_load_pc38 = '0; viol_load_mdp = '0;
    viol_store_pc38 = '0; viol_store_mdp = '0;
    fdep_valid = 1'b0; fdep_pc38 = '0; fdep_mdp = '0;
    #3;
    check("rst_update_valid", 64'(update_valid), 64'd0);
    check("rst_update_pc", 64'(update_pc38), 64'd0);
    check("rst_update_mdp", 64'(update_mdp), 64'd0);
    check("rst_viol_ready", 64'(viol_ready), 64'd1);
    check("rst_fdep_ready", 64'(fdep_ready), 64'd1);
    @(negedge CLK);
    nRST = 1'b1;
    tick();

    // Fresh allocation, then a repeat gets the next id.
    send_viol(38'h100, 8'h00, 38'h200, 8'h00, cyc + 2, cyc + 3);
    viol_valid = 1'b0;
    drain();
    send_viol(38'h100, 8'h00, 38'h200, 8'h00, cyc + 2, cyc + 3);
    viol_valid = 1'b0;
    drain();

    // Merge cases.
    send_viol(38'h110, 8'h45, 38'h210, 8'hC3, cyc + 2, cyc + 3);
    viol_valid = 1'b0;
    drain();
    send_viol(38'h120, 8'h47, 38'h220, 8'h00, cyc + 2, cyc + 3);
    viol_valid = 1'b0;
    drain();

    // False dependence: decay, then a zero-confidence drop.
    fdep_valid = 1'b1; fdep_pc38 = 38'h300; fdep_mdp = 8'h85;
    check("fdep_ready_idle", 64'(fdep_ready), 64'd1);
    sb.push_back('{cyc: cyc + 1, pc: 38'h300, mdp: fdep_model(8'h85)});
    tick();
    fdep_valid = 1'b0;
    drain();
    fdep_valid = 1'b1; fdep_pc38 = 38'h301; fdep_mdp = 8'h05;
    check("fdep_ready_drop", 64'(fdep_ready), 64'd1);
    tick();
    fdep_valid = 1'b0;
    tick(); tick(); tick();

    // Simultaneous fdep and violation while idle: fdep written first.
    fdep_valid = 1'b1; fdep_pc38 = 38'h310; fdep_mdp = 8'hC2;
    check("fdep_ready_simul", 64'(fdep_ready), 64'd1);
    sb.push_back('{cyc: cyc + 1, pc: 38'h310, mdp: fdep_model(8'hC2)});
    send_viol(38'h130, 8'h00, 38'h230, 8'h00, cyc + 2, cyc + 3);
    fdep_valid = 1'b0;
    viol_valid = 1'b0;
    drain();

    // Backpressure: six back-to-back reports, twelve contiguous writes.
    begin
      int base;
      base = cyc;
      saw_full = 1'b0;
      busy_from = base;
      busy_until = base + 12;
      for (int i = 0; i < 6; i++)
        send_viol(38'h400 + 38'(i), 8'h40 | 8'(i), 38'h500 + 38'(i), 8'h00,
                  base + 2 + 2 * i, base + 3 + 2 * i);
      viol_valid = 1'b0;
      drain();
      busy_from = -1;
      busy_until = -1;
      check("viol_ready_dropped", 64'(saw_full), 64'd1);
    end

    // Asynchronous reset in the middle of a write pair.
    send_viol(38'h600, 8'h00, 38'h700, 8'h00, cyc + 2, cyc + 3);
    viol_valid = 1'b0;
    tick();
    tick();
    #2;
    nRST = 1'b0;
    #1;
    check("midrst_update_valid", 64'(update_valid), 64'd0);
    sb.delete();
    m_ctr = 6'd0;
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    check("postrst_viol_ready", 64'(viol_ready), 64'd1);
    check("postrst_fdep_ready", 64'(fdep_ready), 64'd1);
    check("postrst_update_mdp", 64'(update_mdp), 64'd0);
    tick();
    tick();

    // Allocation counter wrap: 65 fresh violations.
    for (int i = 0; i < 65; i++)
      send_viol(38'h800 + 38'(i), 8'h00, 38'h900 + 38'(i), 8'h00, -1, -1);
    viol_valid = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
